cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory line port between the instruction cache and the data cache.
//  - Line-granular: each request moves one cacheline.
//  - Serves one request at a time.
//  - Round-robin tie-break; holds the grant until pmem responds.
//  - Returns data and a one-cycle resp pulse to the owning requester.
//  Sits between the icache/dcache miss paths and the cacheline adaptor feeding pmem.
// PARAMETERS
//  ADDR_W  32   byte address width (line-aligned by requesters)
//  LINE_W  256  cacheline width in bits
// PORTS
//  clk      in   1       clock; all state on rising edge
//  rst      in   1       asynchronous, active-low reset (asserted at 0)
//  i_addr   in   ADDR_W  icache miss line address
//  i_read   in   1       icache line read request; held high until i_resp
//  i_rdata  out  LINE_W  line returned to icache
//  i_resp   out  1       one-cycle done pulse to icache
//  d_addr   in   ADDR_W  dcache line address
//  d_read   in   1       dcache line fill request; held until d_resp
//  d_write  in   1       dcache writeback request; held until d_resp
//  d_wdata  in   LINE_W  writeback line
//  d_rdata  out  LINE_W  line returned to dcache
//  d_resp   out  1       one-cycle done pulse to dcache
//  p_addr   out  ADDR_W  pmem line address (registered)
//  p_read   out  1       pmem read (registered)
//  p_write  out  1       pmem write (registered)
//  p_wdata  out  LINE_W  pmem write line (registered)
//  p_rdata  in   LINE_W  pmem read line, valid with p_resp
//  p_resp   in   1       pmem completion pulse
// BEHAVIOUR
//  Reset (rst=0, async):
//  - State=IDLE, last_grant=ICACHE.
//  - p_read, p_write, i_resp and d_resp are 0.
//  - p_addr, p_wdata, i_rdata and d_rdata are 0.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//  - IDLE: sample i_req=i_read and d_req=d_read|d_write.
//    - Only one requester pending: grant it.
//    - Both pending: grant the requester that is not last_grant.
//    - On grant, at the edge: latch addr/wdata/op into p_*, set owner, update last_grant, go to BUSY.
//  - BUSY: p_* held stable.
//    - On p_resp: clear p_read/p_write, capture p_rdata into owner's *_rdata (reads only), go to RESP.
//  - RESP: owner's resp=1 for exactly one cycle, then back to IDLE.
//    - Requesters drop their request on the edge leaving RESP, so IDLE never re-serves a finished request.
//  Latency: request visible in IDLE at cycle 0.
//  - p_read/p_write high from cycle 1.
//  - p_resp in cycle k gives *_resp in cycle k+1.
//  - Minimum turnaround is 3 cycles per line.
//  Data hold: *_rdata keeps its value until the next read completes for that requester.
//  Non-owner: the non-owning requester's resp stays 0; its request waits with no loss.
//  d_read and d_write both high: illegal; treated as write; simulation assertion fires.
//  Spurious p_resp: ignored in IDLE and RESP.
//  Address rule: no address arithmetic; addresses pass through unchanged (requesters align).
//  Reset mid-BUSY: transaction abandoned.
//  - p_* drop immediately.
//  - A p_resp arriving after reset release is ignored (state IDLE).
//  Starvation: a continuously requesting requester waits at most one foreign transaction.
// STRUCTURE
//  Shared package (rv32i_types-style cache package):
//  - arb_state_t {IDLE, BUSY, RESP}.
//  - arb_owner_t {ICACHE, DCACHE}.
//  Sub-module rr_arbiter2: combinational 2-way round-robin pick from (i_req, d_req, last_grant) -> grant.
//  The FSM and the p_*/rdata registers stay in cache_arbiter.
// TESTING
//  1. i_read only, addr 0x0000_0040; pmem resp after 5 cycles.
//     -> p_read at cycle 1 with p_addr 0x40.
//     -> i_rdata = pmem line and i_resp one pulse at cycle 7.
//     -> d_resp stays 0.
//  2. d_write, addr 0x0000_1000, wdata 0xA5..A5.
//     -> p_write and p_wdata match; p_read=0.
//     -> d_resp one pulse; d_rdata unchanged.
//  3. i_read and d_read high in the same cycle after reset.
//     -> dcache served first (last_grant=ICACHE), then icache.
//     -> third simultaneous pair -> dcache served again.
//  4. Reset asserted while BUSY, then p_resp arrives after release.
//     -> all outputs 0 immediately; no *_resp pulse; state IDLE.
//  5. Back-to-back icache misses, each request dropped the cycle after resp.
//     -> each line served once; spurious p_resp in IDLE causes no resp.
//  6. d_read and d_write both high.
//     -> assertion fires; pmem sees a write.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_arbiter_pkg
// Purpose : shared types for the icache/dcache -> pmem line arbiter.
//           Holds the FSM state encoding, the requester identity used for
//           ownership and round-robin history, and default bus widths.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cache_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } arb_owner_t;

    // The requester that did not win last time.
    function automatic arb_owner_t other_owner(input arb_owner_t o);
        return (o == ICACHE) ? DCACHE : ICACHE;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_arbiter_if
// Purpose : bundles the icache, dcache and pmem line ports of the arbiter.
// Modports:
//   slave  - the arbiter: takes requests/pmem completions, drives pmem and
//            the per-requester data/resp.
//   master - the surrounding system (both caches plus pmem).
// Signals : i_addr/i_read/i_rdata/i_resp   icache miss path
//           d_addr/d_read/d_write/d_wdata/d_rdata/d_resp   dcache path
//           p_addr/p_read/p_write/p_wdata/p_rdata/p_resp   pmem line port
// -----------------------------------------------------------------------------
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] p_addr;
    logic              p_read;
    logic              p_write;
    logic [LINE_W-1:0] p_wdata;
    logic [LINE_W-1:0] p_rdata;
    logic              p_resp;

    modport slave (
        input  i_addr, i_read,
        output i_rdata, i_resp,
        input  d_addr, d_read, d_write, d_wdata,
        output d_rdata, d_resp,
        output p_addr, p_read, p_write, p_wdata,
        input  p_rdata, p_resp
    );

    modport master (
        output i_addr, i_read,
        input  i_rdata, i_resp,
        output d_addr, d_read, d_write, d_wdata,
        input  d_rdata, d_resp,
        input  p_addr, p_read, p_write, p_wdata,
        output p_rdata, p_resp
    );
endinterface

// File: rtl/cache_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Purpose : combinational two-way round-robin pick between icache and dcache.
// Ports   : i_req_i   icache request pending
//           d_req_i   dcache request pending
//           last_i    requester granted most recently
//           valid_o   some requester is pending
//           grant_o   chosen requester (meaningful when valid_o)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import cache_arbiter_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  arb_owner_t last_i,
    output logic       valid_o,
    output arb_owner_t grant_o
);

    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = ICACHE;
        if (i_req_i && d_req_i) begin
            // Contention: the side that lost last time wins now.
            grant_o = other_owner(last_i);
        end else if (d_req_i) begin
            grant_o = DCACHE;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Purpose : shares the single pmem cacheline port between icache and dcache.
//           One line transaction at a time, round-robin on contention, grant
//           held until pmem completes, then a one-cycle resp to the owner.
// Ports   : clk   clock, all state on the rising edge
//           rst   asynchronous reset, active low (asserted at 0)
//           bus   cache_arbiter_if.slave (icache, dcache and pmem line ports)
// Notes   : p_* and *_rdata are registered; *_resp is decoded from the
//           RESP state so it is exactly one cycle wide.
// -----------------------------------------------------------------------------
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        last_q,  last_d;
    logic [ADDR_W-1:0] p_addr_q,  p_addr_d;
    logic              p_read_q,  p_read_d;
    logic              p_write_q, p_write_d;
    logic [LINE_W-1:0] p_wdata_q, p_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic       i_req;
    logic       d_req;
    logic       gnt_valid;
    arb_owner_t gnt;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    rr_arbiter2 u_rr (
        .i_req_i (i_req),
        .d_req_i (d_req),
        .last_i  (last_q),
        .valid_o (gnt_valid),
        .grant_o (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= ICACHE;
            last_q    <= ICACHE;
            p_addr_q  <= '0;
            p_read_q  <= 1'b0;
            p_write_q <= 1'b0;
            p_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            p_addr_q  <= p_addr_d;
            p_read_q  <= p_read_d;
            p_write_q <= p_write_d;
            p_wdata_q <= p_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        p_addr_d  = p_addr_q;
        p_read_d  = p_read_q;
        p_write_d = p_write_q;
        p_wdata_d = p_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    state_d = BUSY;
                    if (gnt == ICACHE) begin
                        p_addr_d  = bus.i_addr;
                        p_read_d  = 1'b1;
                        p_write_d = 1'b0;
                    end else begin
                        // d_read together with d_write is illegal; write wins.
                        p_addr_d  = bus.d_addr;
                        p_write_d = bus.d_write;
                        p_read_d  = ~bus.d_write;
                        p_wdata_d = bus.d_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.p_resp) begin
                    p_read_d  = 1'b0;
                    p_write_d = 1'b0;
                    state_d   = RESP;
                    if (p_read_q) begin
                        if (owner_q == ICACHE) begin
                            i_rdata_d = bus.p_rdata;
                        end else begin
                            d_rdata_d = bus.p_rdata;
                        end
                    end
                end
            end
            RESP: begin
                // p_resp seen here or in IDLE is spurious and ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.p_addr  = p_addr_q;
    assign bus.p_read  = p_read_q;
    assign bus.p_write = p_write_q;
    assign bus.p_wdata = p_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_resp  = (state_q == RESP) && (owner_q == ICACHE);
    assign bus.d_resp  = (state_q == RESP) && (owner_q == DCACHE);

    a_d_rw_exclusive : assert property (
        @(posedge clk) disable iff (!rst) !(bus.d_read && bus.d_write)
    ) else $warning("dcache read and write both high; serving it as a write");

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- environment / reference model state ----------------
    int cyc = 0;
    // requester agents
    logic          i_pend = 1'b0;
    logic [AW-1:0] i_a = '0;
    int            i_wait = 0;
    logic          d_pend = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] d_a = '0;
    logic [LW-1:0] d_wd = '0;
    int            d_wait = 0;
    logic          gen_i = 1'b0, gen_d = 1'b0;
    int            gen_pct = 0;
    // round-robin history as the spec describes it
    arb_owner_t    m_last = ICACHE;
    // pmem agent
    logic          tx_act = 1'b0;
    arb_owner_t    tx_own = ICACHE;
    logic          tx_rd = 1'b0;
    logic [AW-1:0] tx_a = '0;
    logic [LW-1:0] tx_wd = '0;
    int            tx_left = 0;
    int            dly_min = 0, dly_max = 0;
    logic          spur_en = 1'b0, force_spur = 1'b0;
    // expected completion
    int            rsp_cyc = -10;
    arb_owner_t    rsp_own = ICACHE;
    logic          rsp_rd = 1'b0;
    logic [LW-1:0] rsp_line = '0;
    logic [LW-1:0] exp_i_rdata = '0, exp_d_rdata = '0;
    // bookkeeping
    int            n_start = 0, n_i_done = 0, n_d_done = 0;
    int            last_start_cyc = 0, last_resp_cyc = 0;
    logic          last_start_write = 1'b0;
    arb_owner_t    done_log[$];

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic drive();
        bus.i_read  = i_pend;
        bus.i_addr  = i_a;
        bus.d_read  = d_pend & d_rd;
        bus.d_write = d_pend & d_wr;
        bus.d_addr  = d_a;
        bus.d_wdata = d_wd;
    endtask

    task automatic model_reset();
        tx_act = 1'b0;
        rsp_cyc = -10;
        m_last = ICACHE;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        i_pend = 1'b0;
        d_pend = 1'b0;
        bus.p_resp = 1'b0;
        drive();
    endtask

    // One clock: observe outputs of this cycle, advance the model, drive inputs.
    task automatic tick();
        logic          presp;
        logic [LW-1:0] pdat;
        logic [31:0]   r;
        arb_owner_t    eo;
        logic          erd;
        logic [AW-1:0] ea;
        logic          i_drop, d_drop;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 40000) begin
            $display("FAIL watchdog cycles=%0d", cyc);
            $fatal(1, "watchdog");
        end

        // pmem side: a new transaction must follow the round-robin rule
        if (tx_act) begin
            chk("p_addr_hold", bus.p_addr, tx_a);
            chk("p_read_hold", bus.p_read, tx_rd);
            chk("p_write_hold", bus.p_write, !tx_rd);
            if (!tx_rd) chk("p_wdata_hold", bus.p_wdata, tx_wd);
        end else if (bus.p_read || bus.p_write) begin
            chk("start_has_req", i_pend | d_pend, 1'b1);
            if (i_pend && d_pend) eo = (m_last == ICACHE) ? DCACHE : ICACHE;
            else if (d_pend)      eo = DCACHE;
            else                  eo = ICACHE;
            erd = (eo == ICACHE) || !d_wr;
            ea  = (eo == ICACHE) ? i_a : d_a;
            chk("start_addr", bus.p_addr, ea);
            chk("start_read", bus.p_read, erd);
            chk("start_write", bus.p_write, !erd);
            if (!erd) chk("start_wdata", bus.p_wdata, d_wd);
            tx_act = 1'b1;
            tx_own = eo;
            tx_rd  = erd;
            tx_a   = ea;
            tx_wd  = d_wd;
            tx_left = $urandom_range(dly_min, dly_max);
            m_last = eo;
            n_start++;
            last_start_cyc = cyc;
            last_start_write = bus.p_write;
        end

        if (cyc == rsp_cyc) begin
            chk("p_read_clr", bus.p_read, 1'b0);
            chk("p_write_clr", bus.p_write, 1'b0);
            if (rsp_rd) begin
                if (rsp_own == ICACHE) exp_i_rdata = rsp_line;
                else                   exp_d_rdata = rsp_line;
            end
        end
        chk("i_resp", bus.i_resp, (cyc == rsp_cyc) && (rsp_own == ICACHE));
        chk("d_resp", bus.d_resp, (cyc == rsp_cyc) && (rsp_own == DCACHE));
        chk("i_rdata", bus.i_rdata, exp_i_rdata);
        chk("d_rdata", bus.d_rdata, exp_d_rdata);

        // requesters drop on the edge leaving RESP
        if (bus.i_resp || bus.d_resp) last_resp_cyc = cyc;
        i_drop = 1'b0;
        d_drop = 1'b0;
        if (bus.i_resp && i_pend) begin
            i_pend = 1'b0; i_drop = 1'b1; n_i_done++; done_log.push_back(ICACHE);
        end
        if (bus.d_resp && d_pend) begin
            d_pend = 1'b0; d_drop = 1'b1; n_d_done++; done_log.push_back(DCACHE);
        end
        if (i_pend) begin
            i_wait++;
            if (i_wait > 80) begin chk("i_wait_bound", i_wait, 80); i_pend = 1'b0; end
        end
        if (d_pend) begin
            d_wait++;
            if (d_wait > 80) begin chk("d_wait_bound", d_wait, 80); d_pend = 1'b0; end
        end

        if (gen_i && !i_pend && !i_drop && ($urandom_range(0, 99) < gen_pct)) begin
            r = $urandom;
            i_pend = 1'b1; i_wait = 0;
            i_a = {1'b0, r[25:0], 5'b0};
        end
        if (gen_d && !d_pend && !d_drop && ($urandom_range(0, 99) < gen_pct)) begin
            r = $urandom;
            d_pend = 1'b1; d_wait = 0;
            d_a = {1'b1, r[25:0], 5'b0};
            d_wr = r[31];
            d_rd = !r[31];
            d_wd = rand_line();
        end

        presp = 1'b0;
        pdat  = rand_line();
        if (tx_act) begin
            if (tx_left == 0) begin
                presp = 1'b1;
                tx_act = 1'b0;
                rsp_cyc = cyc + 1;
                rsp_own = tx_own;
                rsp_rd = tx_rd;
                rsp_line = pdat;
            end else begin
                tx_left--;
            end
        end else if (!bus.p_read && !bus.p_write &&
                     (force_spur || (spur_en && $urandom_range(0, 3) == 0))) begin
            presp = 1'b1;
        end
        force_spur = 1'b0;
        bus.p_resp  = presp;
        bus.p_rdata = pdat;
        drive();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!i_pend && !d_pend && !tx_act) break;
            tick();
        end
        chk("wait_idle_done", {i_pend, d_pend, tx_act}, 3'b000);
        tick();
        tick();
    endtask

    initial begin
        int t0, base_i, base_d, base_s;

        model_reset();
        bus.p_rdata = '0;
        #1 rst = 1'b0;
        tick();
        tick();
        chk("rst_p_read", bus.p_read, 1'b0);
        chk("rst_p_write", bus.p_write, 1'b0);
        chk("rst_p_addr", bus.p_addr, '0);
        chk("rst_p_wdata", bus.p_wdata, '0);
        chk("rst_i_rdata", bus.i_rdata, '0);
        chk("rst_d_rdata", bus.d_rdata, '0);
        chk("rst_i_resp", bus.i_resp, 1'b0);
        chk("rst_d_resp", bus.d_resp, 1'b0);
        #2 rst = 1'b1;
        tick();

        // simultaneous pairs right after reset: dcache wins first
        dly_min = 1; dly_max = 3;
        for (int p = 0; p < 2; p++) begin
            i_pend = 1'b1; i_wait = 0; i_a = 32'h0000_0100 + 32'(p * 64);
            d_pend = 1'b1; d_wait = 0; d_rd = 1'b1; d_wr = 1'b0;
            d_a = 32'h8000_0200 + 32'(p * 64); d_wd = rand_line();
            drive();
            wait_idle(60);
        end
        chk("t3_order0", done_log[0], DCACHE);
        chk("t3_order1", done_log[1], ICACHE);
        chk("t3_order2", done_log[2], DCACHE);
        chk("t3_order3", done_log[3], ICACHE);

        // single icache miss, pmem answers 5 cycles after p_read rises
        dly_min = 5; dly_max = 5;
        base_i = n_i_done; base_d = n_d_done;
        i_pend = 1'b1; i_wait = 0; i_a = 32'h0000_0040;
        drive();
        t0 = cyc;
        wait_idle(40);
        chk("t1_start_lat", last_start_cyc - t0, 1);
        chk("t1_resp_lat", last_resp_cyc - t0, 7);
        chk("t1_i_done", n_i_done - base_i, 1);
        chk("t1_d_done", n_d_done - base_d, 0);

        // dcache writeback
        dly_min = 2; dly_max = 2;
        d_pend = 1'b1; d_wait = 0; d_rd = 1'b0; d_wr = 1'b1;
        d_a = 32'h0000_1000; d_wd = {32{8'hA5}};
        drive();
        wait_idle(40);
        chk("t2_write_seen", last_start_write, 1'b1);
        chk("t2_d_rdata_held", bus.d_rdata, exp_d_rdata);

        // back-to-back icache misses with spurious p_resp in IDLE
        dly_min = 0; dly_max = 2; spur_en = 1'b1;
        gen_i = 1'b1; gen_pct = 100;
        base_i = n_i_done; base_s = n_start;
        for (int k = 0; k < 200; k++) begin
            if (n_i_done - base_i >= 8) break;
            tick();
        end
        gen_i = 1'b0;
        wait_idle(40);
        chk("t5_served", n_i_done - base_i, n_start - base_s);
        chk("t5_min_count", (n_i_done - base_i) >= 8, 1'b1);
        spur_en = 1'b0;

        // illegal d_read & d_write: served as a write
        dly_min = 1; dly_max = 1;
        d_pend = 1'b1; d_wait = 0; d_rd = 1'b1; d_wr = 1'b1;
        d_a = 32'h0000_2000; d_wd = rand_line();
        drive();
        wait_idle(40);
        chk("t6_write_seen", last_start_write, 1'b1);
        d_rd = 1'b0; d_wr = 1'b0;

        // reset in the middle of BUSY, late p_resp afterwards
        dly_min = 20; dly_max = 20;
        i_pend = 1'b1; i_wait = 0; i_a = 32'h0000_0200;
        drive();
        for (int k = 0; k < 4; k++) tick();
        chk("t4_busy", bus.p_read, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t4_p_read", bus.p_read, 1'b0);
        chk("t4_p_write", bus.p_write, 1'b0);
        chk("t4_p_addr", bus.p_addr, '0);
        chk("t4_p_wdata", bus.p_wdata, '0);
        chk("t4_i_rdata", bus.i_rdata, '0);
        chk("t4_d_rdata", bus.d_rdata, '0);
        chk("t4_i_resp", bus.i_resp, 1'b0);
        chk("t4_d_resp", bus.d_resp, 1'b0);
        model_reset();
        tick();
        #3 rst = 1'b1;
        force_spur = 1'b1;
        base_i = n_i_done;
        for (int k = 0; k < 5; k++) tick();
        chk("t4_no_resp", n_i_done - base_i, 0);
        chk("t4_idle_p_read", bus.p_read, 1'b0);

        // randomized traffic on both requesters
        dly_min = 0; dly_max = 6; spur_en = 1'b1;
        gen_i = 1'b1; gen_d = 1'b1; gen_pct = 30;
        base_i = n_i_done; base_d = n_d_done; base_s = n_start;
        for (int k = 0; k < 3000; k++) tick();
        gen_i = 1'b0; gen_d = 1'b0;
        wait_idle(80);
        chk("rand_balance", (n_i_done - base_i) + (n_d_done - base_d), n_start - base_s);
        chk("rand_both_served", ((n_i_done - base_i) > 10) && ((n_d_done - base_d) > 10), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
